// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit 2-flop synchroniser and stability-counter debouncer
// Emits clean switch levels plus one-cycle rise/fall pulses for each accepted change.
module switch_debouncer #(
  parameter int N       = 16,
  parameter int CNT_MAX = 1_000_000,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_clean,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         changed
);

  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(CNT_MAX - 1);

  logic [N-1:0]     r_sync1;
  logic [N-1:0]     r_sync2;
  logic [N-1:0]     r_clean;
  logic [N-1:0]     r_rise;
  logic [N-1:0]     r_fall;
  logic [CNT_W-1:0] r_cnt [N];

  logic [N-1:0]     w_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < N; i++) begin
        // Any sample matching the current clean level restarts the stability window.
        if (r_sync2[i] == r_clean[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_TERM) begin
          r_clean[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_pulse  = r_rise | r_fall;
  assign sw_clean = r_clean;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;
  assign changed  = |w_pulse;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - randomized and directed check of switch_debouncer against a window model
// The model accepts a bit when the last CNT_MAX synchronised samples all differ from its clean level.
module tb_switch_debouncer;

  localparam int N       = 16;
  localparam int CNT_MAX = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_clean;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic         changed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic [N-1:0] m_hist [CNT_MAX];
  logic [N-1:0] seen_pulse;
  int           n_changed;
  int           n_rise0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .N       (N),
    .CNT_MAX (CNT_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .changed  (changed)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [N-1:0] raw);
    logic [N-1:0] all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
      for (int k = 0; k < CNT_MAX; k++) m_hist[k] = '0;
    end else begin
      for (int k = CNT_MAX - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      all_diff = '1;
      for (int k = 0; k < CNT_MAX; k++) all_diff &= m_hist[k] ^ m_clean;
      m_rise  = all_diff & ~m_clean;
      m_fall  = all_diff & m_clean;
      m_clean = m_clean ^ all_diff;
    end
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] raw);
    reset  = rst;
    sw_raw = raw;
    @(posedge clk);
    model_step(rst, raw);
    #1;
    check_eq("clean", 32'(sw_clean), 32'(m_clean));
    check_eq("rise", 32'(sw_rise), 32'(m_rise));
    check_eq("fall", 32'(sw_fall), 32'(m_fall));
    check_eq("changed", 32'(changed), 32'(|(m_rise | m_fall)));
    check_eq("rise_fall_excl", 32'(sw_rise & sw_fall), 32'(0));
    seen_pulse |= sw_rise | sw_fall;
    if (changed) n_changed++;
    if (sw_rise[0]) n_rise0++;
  endtask

  initial begin
    logic [N-1:0] r;

    // Switches held high through reset report a rise after release.
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 16'hFFFF);
      check_eq("s1_reset_clean", 32'(sw_clean), 32'(0));
      check_eq("s1_reset_changed", 32'(changed), 32'(0));
    end
    for (int c = 1; c <= 5; c++) begin
      cycle(1'b0, 16'hFFFF);
      check_eq("s1_early_clean", 32'(sw_clean), 32'(0));
    end
    cycle(1'b0, 16'hFFFF);
    check_eq("s1_clean", 32'(sw_clean), 32'hFFFF);
    check_eq("s1_rise", 32'(sw_rise), 32'hFFFF);
    check_eq("s1_changed", 32'(changed), 32'(1));
    check_eq("s1_fall", 32'(sw_fall), 32'(0));
    cycle(1'b0, 16'hFFFF);
    check_eq("s1_rise_gone", 32'(sw_rise), 32'(0));
    check_eq("s1_changed_gone", 32'(changed), 32'(0));

    // Short pulse on bit 3 is rejected.
    cycle(1'b1, 16'h0000);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    seen_pulse = '0; n_changed = 0;
    for (int c = 0; c < 3; c++) cycle(1'b0, 16'h0008);
    for (int c = 0; c < 10; c++) cycle(1'b0, 16'h0000);
    check_eq("s2_clean", 32'(sw_clean), 32'(0));
    check_eq("s2_pulses", 32'(seen_pulse), 32'(0));
    check_eq("s2_changed_cnt", 32'(n_changed), 32'(0));

    // Bouncing bit 0 yields one rise, 6 edges after the final 0->1 sample.
    n_rise0 = 0;
    cycle(1'b0, 16'h0001);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0001);
    cycle(1'b0, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      cycle(1'b0, 16'h0001);
      check_eq("s3_early_clean0", 32'(sw_clean[0]), 32'(0));
    end
    cycle(1'b0, 16'h0001);
    check_eq("s3_clean0", 32'(sw_clean[0]), 32'(1));
    check_eq("s3_rise0", 32'(sw_rise[0]), 32'(1));
    for (int c = 0; c < 4; c++) cycle(1'b0, 16'h0001);
    check_eq("s3_rise0_count", 32'(n_rise0), 32'(1));

    // Bit 15 high and settled, then driven low.
    for (int c = 0; c < 8; c++) cycle(1'b0, 16'h8000);
    check_eq("s4_pre_clean", 32'(sw_clean), 32'h8000);
    for (int c = 1; c <= 5; c++) cycle(1'b0, 16'h0000);
    check_eq("s4_early_fall", 32'(sw_fall), 32'(0));
    cycle(1'b0, 16'h0000);
    check_eq("s4_fall", 32'(sw_fall), 32'h8000);
    check_eq("s4_rise", 32'(sw_rise), 32'(0));
    check_eq("s4_clean", 32'(sw_clean), 32'(0));

    // Simultaneous rise on bit 1 and fall on bit 2.
    for (int c = 0; c < 8; c++) cycle(1'b0, 16'h0004);
    for (int c = 1; c <= 5; c++) cycle(1'b0, 16'h0002);
    cycle(1'b0, 16'h0002);
    check_eq("s5_rise", 32'(sw_rise), 32'h0002);
    check_eq("s5_fall", 32'(sw_fall), 32'h0004);
    check_eq("s5_changed", 32'(changed), 32'(1));

    // Reset mid-count on bit 5 discards the partial count.
    for (int c = 0; c < 4; c++) cycle(1'b0, 16'h0022);
    check_eq("s6_pre_clean5", 32'(sw_clean[5]), 32'(0));
    cycle(1'b1, 16'h0022);
    check_eq("s6_reset_clean", 32'(sw_clean), 32'(0));
    for (int c = 1; c <= 5; c++) begin
      cycle(1'b0, 16'h0022);
      check_eq("s6_early_clean5", 32'(sw_clean[5]), 32'(0));
    end
    cycle(1'b0, 16'h0022);
    check_eq("s6_clean", 32'(sw_clean), 32'h0022);
    check_eq("s6_rise", 32'(sw_rise), 32'h0022);

    // Randomized bouncing with occasional reset, checked against the model each cycle.
    r = sw_raw;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      cycle($urandom_range(0, 149) == 0, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
